// File: rtl/sum_pkg.sv
// -----------------------------------------------------------------------------
// sum_pkg
//
// Constants and types shared by the 1-to-100 summation unit and its
// downstream BCD converter (result_bcd).
//
//   SUM_RESULT_W : width of the summation unit's binary `result` bus
//   SUM_DIGITS   : number of decimal digits shown by the display stage
//   bcd_state_t  : control states of the BCD conversion engine
// -----------------------------------------------------------------------------
package sum_pkg;

    // 13 bits holds the sum 1..100 = 5050; 4 digits cover 0..8191.
    localparam int SUM_RESULT_W = 13;
    localparam int SUM_DIGITS   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DONE    = 2'd2
    } bcd_state_t;

endpackage : sum_pkg

// File: rtl/bcd_add3.sv
// -----------------------------------------------------------------------------
// bcd_add3
//
// Combinational correction step for one BCD nibble in a shift-and-add-3
// (double dabble) converter: a nibble of 5 or more gets 3 added so that the
// following left shift carries correctly into the next decimal digit.
// Legal inputs are 0..9, so the output never exceeds 12 and never carries.
//
// Ports:
//   din  : nibble before correction
//   dout : corrected nibble
// -----------------------------------------------------------------------------
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule : bcd_add3

// File: rtl/result_bcd.sv
// -----------------------------------------------------------------------------
// result_bcd
//
// Captures the summation unit's binary `result` on a rising edge of `finish`
// and converts it to packed BCD with a sequential double dabble engine, one
// bit per clock. The finished digits are offered to a display/host consumer.
//
// Handshake: `bcd_valid` is high while `bcd` holds a completed conversion
// that has not yet been accepted. The consumer accepts by raising `bcd_ack`
// for a cycle while `bcd_valid` is high; `bcd_valid` falls on that edge and
// `bcd` keeps its value. `bcd_ack` while `bcd_valid` is low has no effect.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   finish    : done level from the summation unit
//   result    : binary sum, valid while `finish` is high
//   bcd       : packed BCD, most significant digit in the top nibble
//   bcd_valid : `bcd` holds an unconsumed completed conversion
//   bcd_ack   : consumer accepts `bcd`
//   busy      : a conversion is in progress
//   dropped   : sticky; a `finish` rising edge was ignored or a result
//               was overwritten before being consumed (cleared by reset)
//   dbg_state : current control state (bcd_state_t encoding)
//
// RESULT_W/DIGITS must satisfy 10**DIGITS > 2**RESULT_W - 1, otherwise the
// top digit of the conversion does not fit.
// -----------------------------------------------------------------------------
module result_bcd
    import sum_pkg::*;
#(
    parameter int RESULT_W = SUM_RESULT_W,
    parameter int DIGITS   = SUM_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  finish,
    input  logic [RESULT_W-1:0]   result,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    input  logic                  bcd_ack,
    output logic                  busy,
    output logic                  dropped,
    output logic [1:0]            dbg_state
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + RESULT_W;
    localparam int CNT_W = $clog2(RESULT_W + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(RESULT_W - 1);

    bcd_state_t        state;
    bcd_state_t        state_next;

    logic              finish_q;
    logic              start;

    // Shift register: {BCD field, binary field}.
    logic [SR_W-1:0]   sr;
    logic [CNT_W-1:0]  cnt;

    logic [BCD_W-1:0]  bcd_fixed;
    logic [SR_W-1:0]   sr_shifted;

    // Control strobes from the FSM to the datapath.
    logic              do_load;
    logic              do_step;
    logic              do_capture;
    logic              set_dropped;

    // ------------------------------------------------------------------------
    // Start event: rising edge of `finish`. finish_q resets to 0, so a
    // `finish` already high when reset releases still yields one start.
    // ------------------------------------------------------------------------
    assign start = finish & ~finish_q;

    // ------------------------------------------------------------------------
    // One double dabble iteration: correct every BCD nibble, then shift the
    // whole register left by one.
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (sr[RESULT_W + 4*g +: 4]),
            .dout (bcd_fixed[4*g +: 4])
        );
    end

    assign sr_shifted = {bcd_fixed[BCD_W-2:0], sr[RESULT_W-1:0], 1'b0};

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and datapath strobes
    // ------------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        do_load     = 1'b0;
        do_step     = 1'b0;
        do_capture  = 1'b0;
        set_dropped = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    do_load    = 1'b1;
                    state_next = CONVERT;
                end
            end

            CONVERT: begin
                do_step = 1'b1;
                // A new result cannot be taken mid-conversion; the original
                // capture runs to completion and the loss is flagged.
                if (start) begin
                    set_dropped = 1'b1;
                end
                if (cnt == LAST_ITER) begin
                    do_capture = 1'b1;
                    state_next = DONE;
                end
            end

            DONE: begin
                if (start) begin
                    // Newer result replaces the pending one. It is only a
                    // loss if the consumer did not take the old one this cycle.
                    do_load    = 1'b1;
                    state_next = CONVERT;
                    if (!bcd_ack) begin
                        set_dropped = 1'b1;
                    end
                end else if (bcd_ack) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            finish_q <= 1'b0;
            sr       <= '0;
            cnt      <= '0;
            bcd      <= '0;
            dropped  <= 1'b0;
        end else begin
            finish_q <= finish;

            if (do_load) begin
                sr  <= {{BCD_W{1'b0}}, result};
                cnt <= '0;
            end else if (do_step) begin
                sr  <= sr_shifted;
                cnt <= cnt + 1'b1;
            end

            // The last iteration's shifted BCD field is the final answer;
            // take it straight from the shifter rather than a cycle later.
            if (do_capture) begin
                bcd <= sr_shifted[SR_W-1 -: BCD_W];
            end

            if (set_dropped) begin
                dropped <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Status outputs
    // ------------------------------------------------------------------------
    assign bcd_valid = (state == DONE);
    assign busy      = (state == CONVERT);
    assign dbg_state = state;

endmodule : result_bcd

// File: tb/tb_result_bcd.sv
module tb_result_bcd;

    localparam int RESULT_W = 13;
    localparam int DIGITS   = 4;
    localparam int BCD_W    = 4 * DIGITS;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                finish = 1'b0;
    logic [RESULT_W-1:0] result = '0;
    logic [BCD_W-1:0]    bcd;
    logic                bcd_valid;
    logic                bcd_ack = 1'b0;
    logic                busy;
    logic                dropped;
    logic [1:0]          dbg_state;

    always #5 clk = ~clk;

    result_bcd #(.RESULT_W(RESULT_W), .DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .finish    (finish),
        .result    (result),
        .bcd       (bcd),
        .bcd_valid (bcd_valid),
        .bcd_ack   (bcd_ack),
        .busy      (busy),
        .dropped   (dropped),
        .dbg_state (dbg_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard state
    // ------------------------------------------------------------------
    logic [BCD_W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int ncyc    = 0;
    int busy_start = 0;
    int busy_rises = 0;
    int valid_rises = 0;
    logic busy_p  = 1'b0;
    logic valid_p = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: decimal digits by plain division.
    function automatic logic [BCD_W-1:0] to_bcd(input int v);
        logic [BCD_W-1:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Monitor: pops on each bcd_valid rise, checks value and latency
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst) begin
            if (busy && !busy_p) begin
                busy_start = ncyc;
                busy_rises++;
            end
            if (bcd_valid && !valid_p) begin
                valid_rises++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {16'd0, bcd}, 32'hFFFF_FFFF);
                end else begin
                    logic [BCD_W-1:0] e;
                    e = exp_q.pop_front();
                    check("bcd_value", {16'd0, bcd}, {16'd0, e});
                    check("latency", ncyc - busy_start, RESULT_W);
                end
            end
        end
        busy_p  = busy;
        valid_p = bcd_valid;
        ncyc++;
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0; finish = 1'b0; bcd_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bcd", {16'd0, bcd}, 32'd0);
        check("rst_valid", {31'd0, bcd_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_dropped", {31'd0, dropped}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    // Raise finish for one cycle; start is sampled at the next edge.
    task automatic start_conv(input int v, input bit push, input bit with_ack);
        @(posedge clk); #1;
        result  = RESULT_W'(v);
        finish  = 1'b1;
        bcd_ack = with_ack;
        if (push) exp_q.push_back(to_bcd(v));
        @(posedge clk); #1;
        finish  = 1'b0;
        bcd_ack = 1'b0;
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        @(negedge clk);
        while (!bcd_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (!bcd_valid) check("valid_timeout", 32'd0, 32'd1);
    endtask

    task automatic ack_pulse();
        @(posedge clk); #1;
        bcd_ack = 1'b1;
        @(posedge clk); #1;
        bcd_ack = 1'b0;
        @(negedge clk);
        check("ack_valid_low", {31'd0, bcd_valid}, 32'd0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        logic [BCD_W-1:0] held;
        int v;

        do_reset();

        // 5050, then hold in DONE without ack
        start_conv(5050, 1'b1, 1'b0);
        wait_valid();
        held = bcd;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, bcd_valid}, 32'd1);
            check("hold_bcd", {16'd0, bcd}, 32'h5050);
        end
        ack_pulse();
        check("bcd_retained", {16'd0, bcd}, 32'h5050);
        @(negedge clk);
        check("idle_after_ack_busy", {31'd0, busy}, 32'd0);

        // Boundary values
        start_conv(0, 1'b1, 1'b0);    wait_valid(); ack_pulse();
        check("bcd_zero", {16'd0, bcd}, 32'h0000);
        start_conv(8191, 1'b1, 1'b0); wait_valid(); ack_pulse();
        check("bcd_max", {16'd0, bcd}, 32'h8191);
        start_conv(100, 1'b1, 1'b0);  wait_valid(); ack_pulse();
        check("bcd_100", {16'd0, bcd}, 32'h0100);

        // Randomized values
        for (int i = 0; i < 25; i++) begin
            v = int'($urandom_range(0, 8191));
            start_conv(v, 1'b1, 1'b0);
            wait_valid();
            ack_pulse();
        end
        check("no_drop_yet", {31'd0, dropped}, 32'd0);

        // Start during CONVERT is ignored and flagged
        start_conv(5050, 1'b1, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("busy_mid", {31'd0, busy}, 32'd1);
        start_conv(1, 1'b0, 1'b0);
        wait_valid();
        check("drop_conv", {31'd0, dropped}, 32'd1);
        check("drop_keeps_first", {16'd0, bcd}, 32'h5050);
        ack_pulse();

        // Overwrite in DONE without ack
        do_reset();
        start_conv(1234, 1'b1, 1'b0);
        wait_valid();
        start_conv(55, 1'b1, 1'b0);
        @(negedge clk);
        check("ovw_valid_low", {31'd0, bcd_valid}, 32'd0);
        check("ovw_dropped", {31'd0, dropped}, 32'd1);
        check("ovw_busy", {31'd0, busy}, 32'd1);
        wait_valid();
        check("ovw_bcd", {16'd0, bcd}, 32'h0055);
        ack_pulse();

        // Overwrite in DONE with ack in the same cycle
        do_reset();
        start_conv(77, 1'b1, 1'b0);
        wait_valid();
        start_conv(55, 1'b1, 1'b1);
        @(negedge clk);
        check("ack_ovw_valid_low", {31'd0, bcd_valid}, 32'd0);
        check("ack_ovw_dropped", {31'd0, dropped}, 32'd0);
        wait_valid();
        check("ack_ovw_bcd", {16'd0, bcd}, 32'h0055);
        ack_pulse();

        // Reset mid-conversion, finish held high through release
        start_conv(4321, 1'b1, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("async_bcd", {16'd0, bcd}, 32'd0);
        check("async_valid", {31'd0, bcd_valid}, 32'd0);
        check("async_busy", {31'd0, busy}, 32'd0);
        check("async_dropped", {31'd0, dropped}, 32'd0);
        exp_q.delete();
        result = RESULT_W'(999);
        finish = 1'b1;
        @(posedge clk); #1;
        exp_q.push_back(to_bcd(999));
        busy_rises  = 0;
        valid_rises = 0;
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("held_one_busy", busy_rises, 32'd1);
        check("held_one_valid", valid_rises, 32'd1);
        check("held_bcd", {16'd0, bcd}, 32'h0999);
        finish = 1'b0;
        ack_pulse();

        repeat (3) @(posedge clk);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (tests %0d)", n_tests);
        $fatal(1);
    end

endmodule : tb_result_bcd
